pipe_ctrl_unit: RTL and testbench

- Successor to the single-cycle main decoder: decodes the ID-stage opcode and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers of the 5-stage pipeline.
- Detects load-use hazards and inserts bubbles.
- Resolves taken branches in EX and jumps in ID, driving the PC-select and IF/ID flush.
- Unsupported opcodes decode to a NOP and raise a flag. Control signals never hold their previous value.

---
 rtl/ctrl_pkg.sv | 69 ++++++
 rtl/ctrl_decode.sv | 71 +++++++
 rtl/pipe_ctrl_unit.sv | 129 ++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcodes, ALUOp encodings and per-stage control bundle types for the 5-stage pipeline.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LOGIC = 2'b11;

  // Full decoded bundle as produced in ID.
  typedef struct packed {
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       branch;
    logic       jump;
    logic       jal;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       illegal;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = '0;

  // Controls still needed once the instruction has left EX.
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
    logic jal;
  } ctl_mem_t;

  // Controls still needed once the instruction has left MEM.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic jal;
  } ctl_wb_t;

  // ID/EX contents; the jump bit is consumed in ID and not carried on.
  typedef struct packed {
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       branch;
    logic       illegal;
    ctl_mem_t   m;
  } ctl_ex_t;

  // Opcodes whose rt field is a source operand (and so can cause a load-use hazard).
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Main decoder: opcode + valid -> control bundle, unsupported opcodes give a NOP with illegal set.
// Latency: purely combinational.
// Backpressure: none.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W         = 6,
  parameter int EN_LOGIC_IMM = 1
) (
  input  logic            valid_i,
  input  logic [OP_W-1:0] op_i,
  output ctrl_bundle_t    ctrl_o
);

  logic [5:0] op6;
  assign op6 = 6'(op_i);

  // Truth table; every field defaults to 0 so no control can linger.
  always_comb begin
    ctrl_o = CTRL_NOP;
    if (valid_i) begin
      case (op6)
        OP_RTYPE: begin
          ctrl_o.reg_dst   = 1'b1;
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_op    = ALU_FUNCT;
        end
        OP_LW: begin
          ctrl_o.alu_src    = 1'b1;
          ctrl_o.mem_read   = 1'b1;
          ctrl_o.mem_to_reg = 1'b1;
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.alu_op     = ALU_ADD;
        end
        OP_SW: begin
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.mem_write = 1'b1;
          ctrl_o.alu_op    = ALU_ADD;
        end
        OP_BEQ: begin
          ctrl_o.branch = 1'b1;
          ctrl_o.alu_op = ALU_SUB;
        end
        OP_J: begin
          ctrl_o.jump = 1'b1;
        end
        OP_JAL: begin
          ctrl_o.jump      = 1'b1;
          ctrl_o.jal       = 1'b1;
          ctrl_o.reg_write = 1'b1;
        end
        OP_ADDI: begin
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_op    = ALU_ADD;
        end
        OP_ANDI, OP_ORI: begin
          if (EN_LOGIC_IMM != 0) begin
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_op    = ALU_LOGIC;
          end else begin
            ctrl_o.illegal = 1'b1;
          end
        end
        default: ctrl_o.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control: ID decode, ID/EX-EX/MEM-MEM/WB control registers, load-use stall, branch/jump redirect.
// Latency: ex_* 1 cycle after ID, mem_* 2, wb_* 3; PC/IF-ID controls combinational.
// Backpressure: load-use holds PC and IF/ID for one cycle and injects a bubble into ID/EX.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int OP_W         = 6,
  parameter int REG_W        = 5,
  parameter int CNT_W        = 16,
  parameter int EN_LOGIC_IMM = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [OP_W-1:0]  id_op,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_zero,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             pc_src_branch,
  output logic             pc_src_jump,
  output logic             ex_alu_src,
  output logic             ex_reg_dst,
  output logic [1:0]       ex_alu_op,
  output logic             ex_branch,
  output logic             ex_illegal,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_reg_write,
  output logic             wb_mem_to_reg,
  output logic             wb_jal,
  output logic [CNT_W-1:0] stall_count
);

  ctrl_bundle_t     id_ctrl;
  ctl_ex_t          idex_d, idex_q;
  ctl_mem_t         exmem_q;
  ctl_wb_t          memwb_q;
  logic [REG_W-1:0] ex_rt_d, ex_rt_q;
  logic [CNT_W-1:0] stall_count_d, stall_count_q;

  logic branch_taken;
  logic load_use;
  logic stall;
  logic jump_go;
  logic bubble;

  ctrl_decode #(
    .OP_W        (OP_W),
    .EN_LOGIC_IMM(EN_LOGIC_IMM)
  ) u_decode (
    .valid_i(id_valid),
    .op_i   (id_op),
    .ctrl_o (id_ctrl)
  );

  // Hazard detection and redirect priority: branch taken > load-use stall > jump.
  always_comb begin
    branch_taken = idex_q.branch & ex_zero;
    load_use     = idex_q.m.mem_read & (ex_rt_q != '0) & id_valid &
                   ((ex_rt_q == id_rs) | ((ex_rt_q == id_rt) & reads_rt(6'(id_op))));
    stall        = load_use & ~branch_taken;
    jump_go      = id_ctrl.jump & ~branch_taken & ~stall;
    bubble       = branch_taken | stall;

    pc_write      = ~stall;
    ifid_write    = ~stall;
    ifid_flush    = branch_taken | jump_go;
    pc_src_branch = branch_taken;
    pc_src_jump   = jump_go;
  end

  // Next ID/EX contents: decoded bundle, or an all-zero bubble on stall/taken branch.
  always_comb begin
    idex_d              = '0;
    ex_rt_d             = '0;
    stall_count_d       = stall_count_q;
    if (!bubble) begin
      idex_d.alu_src      = id_ctrl.alu_src;
      idex_d.reg_dst      = id_ctrl.reg_dst;
      idex_d.alu_op       = id_ctrl.alu_op;
      idex_d.branch       = id_ctrl.branch;
      idex_d.illegal      = id_ctrl.illegal;
      idex_d.m.mem_read   = id_ctrl.mem_read;
      idex_d.m.mem_write  = id_ctrl.mem_write;
      idex_d.m.reg_write  = id_ctrl.reg_write;
      idex_d.m.mem_to_reg = id_ctrl.mem_to_reg;
      idex_d.m.jal        = id_ctrl.jal;
      ex_rt_d             = id_rt;
    end
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // Stage registers and stall counter; reset flushes every in-flight control.
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q        <= '0;
      ex_rt_q       <= '0;
      exmem_q       <= '0;
      memwb_q       <= '0;
      stall_count_q <= '0;
    end else begin
      idex_q             <= idex_d;
      ex_rt_q            <= ex_rt_d;
      exmem_q            <= idex_q.m;
      memwb_q.reg_write  <= exmem_q.reg_write;
      memwb_q.mem_to_reg <= exmem_q.mem_to_reg;
      memwb_q.jal        <= exmem_q.jal;
      stall_count_q      <= stall_count_d;
    end
  end

  assign ex_alu_src    = idex_q.alu_src;
  assign ex_reg_dst    = idex_q.reg_dst;
  assign ex_alu_op     = idex_q.alu_op;
  assign ex_branch     = idex_q.branch;
  assign ex_illegal    = idex_q.illegal;
  assign mem_read      = exmem_q.mem_read;
  assign mem_write     = exmem_q.mem_write;
  assign wb_reg_write  = memwb_q.reg_write;
  assign wb_mem_to_reg = memwb_q.mem_to_reg;
  assign wb_jal        = memwb_q.jal;
  assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: two instances (default config, and CNT_W=2 with logic-imm disabled).
// Latency: checks combinational outputs mid-cycle, registered outputs against a pipeline model.
// Backpressure: not applicable.
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [5:0] id_op;
  logic [4:0] id_rs, id_rt;
  logic       ex_zero;

  always #5 clk = ~clk;

  // Instance 0 outputs
  logic        a_pcw, a_ifw, a_ifl, a_psb, a_psj, a_als, a_rd, a_br, a_ill, a_mr, a_mw, a_rw, a_m2r, a_jal;
  logic [1:0]  a_aop;
  logic [15:0] a_cnt;
  // Instance 1 outputs
  logic        b_pcw, b_ifw, b_ifl, b_psb, b_psj, b_als, b_rd, b_br, b_ill, b_mr, b_mw, b_rw, b_m2r, b_jal;
  logic [1:0]  b_aop;
  logic [1:0]  b_cnt;

  pipe_ctrl_unit u_dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
    .ex_zero(ex_zero), .pc_write(a_pcw), .ifid_write(a_ifw), .ifid_flush(a_ifl),
    .pc_src_branch(a_psb), .pc_src_jump(a_psj), .ex_alu_src(a_als), .ex_reg_dst(a_rd),
    .ex_alu_op(a_aop), .ex_branch(a_br), .ex_illegal(a_ill), .mem_read(a_mr), .mem_write(a_mw),
    .wb_reg_write(a_rw), .wb_mem_to_reg(a_m2r), .wb_jal(a_jal), .stall_count(a_cnt)
  );

  pipe_ctrl_unit #(.CNT_W(2), .EN_LOGIC_IMM(0)) u_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
    .ex_zero(ex_zero), .pc_write(b_pcw), .ifid_write(b_ifw), .ifid_flush(b_ifl),
    .pc_src_branch(b_psb), .pc_src_jump(b_psj), .ex_alu_src(b_als), .ex_reg_dst(b_rd),
    .ex_alu_op(b_aop), .ex_branch(b_br), .ex_illegal(b_ill), .mem_read(b_mr), .mem_write(b_mw),
    .wb_reg_write(b_rw), .wb_mem_to_reg(b_m2r), .wb_jal(b_jal), .stall_count(b_cnt)
  );

  // Reference model: one decoded record per in-flight instruction, shifted through three slots.
  typedef struct packed {
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       branch;
    logic       jal;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       illegal;
  } rec_t;

  rec_t       m_ex[2], m_mem[2], m_wb[2];
  logic [4:0] m_rt[2];
  int         m_cnt[2];
  int         m_max[2];
  int         checks = 0;
  int         failures = 0;

  function automatic rec_t decode(input logic v, input logic [5:0] op, input bit en);
    rec_t r;
    r = '0;
    if (v) begin
      case (op)
        6'd0:  begin r.reg_dst = 1; r.reg_write = 1; r.alu_op = 2'b10; end
        6'd35: begin r.alu_src = 1; r.mem_read = 1; r.mem_to_reg = 1; r.reg_write = 1; end
        6'd43: begin r.alu_src = 1; r.mem_write = 1; end
        6'd4:  begin r.branch = 1; r.alu_op = 2'b01; end
        6'd2:  ;
        6'd3:  begin r.jal = 1; r.reg_write = 1; end
        6'd8:  begin r.alu_src = 1; r.reg_write = 1; end
        6'd12, 6'd13: begin
          if (en) begin r.alu_src = 1; r.reg_write = 1; r.alu_op = 2'b11; end
          else r.illegal = 1;
        end
        default: r.illegal = 1;
      endcase
    end
    return r;
  endfunction

  // Expected {pc_write, ifid_write, ifid_flush, pc_src_branch, pc_src_jump} for instance k.
  function automatic logic [4:0] comb_exp(input int k);
    logic taken, lu, stl, jmp, pj;
    taken = m_ex[k].branch & ex_zero;
    lu    = m_ex[k].mem_read && (m_rt[k] != 0) && id_valid &&
            ((m_rt[k] == id_rs) || ((m_rt[k] == id_rt) && (id_op == 6'd0 || id_op == 6'd4 || id_op == 6'd43)));
    stl   = lu && !taken;
    jmp   = id_valid && (id_op == 6'd2 || id_op == 6'd3);
    pj    = jmp && !taken && !stl;
    return {!stl, !stl, taken | pj, taken, pj};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    chk({where, " i0 comb"}, 32'({a_pcw, a_ifw, a_ifl, a_psb, a_psj}), 32'(comb_exp(0)));
    chk({where, " i0 ex"},   32'({a_als, a_rd, a_aop, a_br, a_ill}),
        32'({m_ex[0].alu_src, m_ex[0].reg_dst, m_ex[0].alu_op, m_ex[0].branch, m_ex[0].illegal}));
    chk({where, " i0 mem"},  32'({a_mr, a_mw}), 32'({m_mem[0].mem_read, m_mem[0].mem_write}));
    chk({where, " i0 wb"},   32'({a_rw, a_m2r, a_jal}),
        32'({m_wb[0].reg_write, m_wb[0].mem_to_reg, m_wb[0].jal}));
    chk({where, " i0 cnt"},  32'(a_cnt), 32'(m_cnt[0]));
    chk({where, " i1 comb"}, 32'({b_pcw, b_ifw, b_ifl, b_psb, b_psj}), 32'(comb_exp(1)));
    chk({where, " i1 ex"},   32'({b_als, b_rd, b_aop, b_br, b_ill}),
        32'({m_ex[1].alu_src, m_ex[1].reg_dst, m_ex[1].alu_op, m_ex[1].branch, m_ex[1].illegal}));
    chk({where, " i1 mem"},  32'({b_mr, b_mw}), 32'({m_mem[1].mem_read, m_mem[1].mem_write}));
    chk({where, " i1 wb"},   32'({b_rw, b_m2r, b_jal}),
        32'({m_wb[1].reg_write, m_wb[1].mem_to_reg, m_wb[1].jal}));
    chk({where, " i1 cnt"},  32'(b_cnt), 32'(m_cnt[1]));
  endtask

  // One clock: drive inputs, check mid-cycle, then advance the model on the edge.
  task automatic step(input string where, input logic r, input logic v, input logic [5:0] op,
                      input logic [4:0] rs, input logic [4:0] rt, input logic z, input bit do_chk);
    logic [4:0] c;
    reset = r; id_valid = v; id_op = op; id_rs = rs; id_rt = rt; ex_zero = z;
    @(negedge clk);
    if (do_chk) check_all(where);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      c = comb_exp(k);
      if (r) begin
        m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_rt[k] = '0; m_cnt[k] = 0;
      end else begin
        m_wb[k]  = m_mem[k];
        m_mem[k] = m_ex[k];
        if (c[1] || !c[4]) begin
          m_ex[k] = '0; m_rt[k] = '0;
        end else begin
          m_ex[k] = decode(v, op, k == 0); m_rt[k] = rt;
        end
        if (!c[4] && m_cnt[k] < m_max[k]) m_cnt[k]++;
      end
    end
    #1;
  endtask

  logic [5:0] ops[10];

  initial begin
    ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd3, 6'd8, 6'd12, 6'd13, 6'd63};
    m_max[0] = 65535; m_max[1] = 3;
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_rt[k] = '0; m_cnt[k] = 0;
    end
    reset = 1'b1; id_valid = 1'b0; id_op = '0; id_rs = '0; id_rt = '0; ex_zero = 1'b0;
    @(posedge clk); #1;

    // Reset held with random inputs; the first edge is unchecked because registers start unknown.
    step("rst0", 1, 1'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 0);
    for (int i = 0; i < 3; i++)
      step("rst", 1, 1'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1);

    // First add after release, then drain so it reaches WB.
    step("add", 0, 1, 6'd0, 5'd1, 5'd3, 0, 1);
    step("add+1", 0, 0, 6'd0, 5'd0, 5'd0, 0, 1);

    // Load-use on rs, then same consumer again once the bubble is in EX.
    step("lw r2", 0, 1, 6'd35, 5'd0, 5'd2, 0, 1);
    step("lu stall", 0, 1, 6'd0, 5'd2, 5'd5, 0, 1);
    step("lu after", 0, 1, 6'd0, 5'd2, 5'd5, 0, 1);
    // rt=0 load never stalls.
    step("lw r0", 0, 1, 6'd35, 5'd0, 5'd0, 0, 1);
    step("lu r0", 0, 1, 6'd0, 5'd0, 5'd0, 0, 1);
    // rt match only counts for R-type/beq/sw: addi reading rt must not stall.
    step("lw r3", 0, 1, 6'd35, 5'd0, 5'd3, 0, 1);
    step("addi rt", 0, 1, 6'd8, 5'd1, 5'd3, 0, 1);
    step("lw r3b", 0, 1, 6'd35, 5'd0, 5'd3, 0, 1);
    step("sw rt", 0, 1, 6'd43, 5'd1, 5'd3, 0, 1);

    // Branch taken, then branch taken with a jump in ID.
    step("beq", 0, 1, 6'd4, 5'd1, 5'd1, 0, 1);
    step("taken", 0, 1, 6'd0, 5'd1, 5'd2, 1, 1);
    step("beq2", 0, 1, 6'd4, 5'd1, 5'd1, 0, 1);
    step("taken+jal", 0, 1, 6'd3, 5'd0, 5'd0, 1, 1);
    step("beq ntk", 0, 1, 6'd4, 5'd1, 5'd1, 0, 1);
    step("not taken", 0, 1, 6'd0, 5'd1, 5'd2, 0, 1);

    // jal proceeds down to WB.
    step("jal", 0, 1, 6'd3, 5'd0, 5'd0, 0, 1);
    for (int i = 0; i < 3; i++) step("jal drain", 0, 0, 6'd0, 5'd0, 5'd0, 0, 1);

    // jal held by a load-use stall, then redirected the next cycle.
    step("lw r4", 0, 1, 6'd35, 5'd0, 5'd4, 0, 1);
    step("jal stall", 0, 1, 6'd3, 5'd4, 5'd0, 0, 1);
    step("jal retry", 0, 1, 6'd3, 5'd4, 5'd0, 0, 1);

    // Illegal opcode and logic-imm mode differences.
    step("ill", 0, 1, 6'd63, 5'd0, 5'd0, 0, 1);
    step("andi", 0, 1, 6'd12, 5'd0, 5'd0, 0, 1);
    step("ori", 0, 1, 6'd13, 5'd0, 5'd0, 0, 1);
    step("ill invalid", 0, 0, 6'd63, 5'd0, 5'd0, 0, 1);
    step("idle", 0, 0, 6'd0, 5'd0, 5'd0, 0, 1);

    // Five load-use stalls: the 2-bit counter must hold at 3.
    for (int i = 0; i < 5; i++) begin
      step("sat lw", 0, 1, 6'd35, 5'd0, 5'd1, 0, 1);
      step("sat use", 0, 1, 6'd0, 5'd1, 5'd0, 0, 1);
    end
    step("sat end", 0, 0, 6'd0, 5'd0, 5'd0, 0, 1);

    // Mid-operation reset discards in-flight controls.
    step("pre rst", 0, 1, 6'd35, 5'd0, 5'd1, 0, 1);
    step("mid rst", 1, 1, 6'd0, 5'd1, 5'd0, 0, 1);
    step("post rst", 0, 0, 6'd0, 5'd0, 5'd0, 0, 1);

    // Randomised traffic with small register range for frequent hazards.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 7) != 0),
           ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
